regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write, two-read core regfile.
- Generalises XLEN, register count, read-port count and write-port count.
- Adds a sequential clear engine that zeroes every register after reset or on request, with a ready indication.
- Sits in the decode/writeback stage. Read ports feed operand fetch; write ports are driven by writeback lanes.

Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of read ports, >= 1.
- NWR, 2, number of write ports, >= 1.
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- clr_req  input  1  request a full re-clear; sampled only in RUN.
- ready  output  1  high when the file is in RUN (reads valid, writes accepted).
- rs_addr  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]. AW = $clog2(NREGS).
- rs_data  output  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
- wr_en  input  NWR  per-port write enable.
- wr_addr  input  NWR*AW  packed write addresses.
- wr_data  input  NWR*XLEN  packed write data.

Behaviour:
- FSM states CLEAR and RUN; clear pointer clr_ptr is AW bits wide.
- Reset (rst_n low at posedge): state <= CLEAR, clr_ptr <= 0. ready is 0 during and after reset until clearing completes.
- Register array contents are not reset directly; only the clear engine zeroes them.
- CLEAR:
  - Each cycle writes 0 to regs[clr_ptr], then clr_ptr <= clr_ptr + 1.
  - When clr_ptr == NREGS-1, the final register is written and state <= RUN.
  - The clear occupies exactly NREGS cycles; ready rises in the cycle after the last clear write.
  - All wr_en are ignored.
  - All rs_data read as 0.
  - clr_req is ignored.
- RUN:
  - ready = 1.
  - clr_req = 1 at a posedge: state <= CLEAR, clr_ptr <= 0. Writes presented in that same cycle are still committed.
- Reset asserted mid-clear restarts the clear from 0.
- Reads:
  - Combinational, zero latency.
  - rs_data[i] = regs[rs_addr[i]].
  - If ZERO_REG=1 and the address is 0, the result is 0.
- Writes:
  - Committed at posedge when state == RUN and wr_en[j] = 1.
  - Dropped when ZERO_REG=1 and wr_addr[j] == 0.
- Write collision (two enabled ports, same address): the highest-index port wins; the others are dropped silently.
- Read-during-write, without bypass: returns the pre-write value; the new value is visible from the next cycle.
- No arithmetic on data; data passes through unchanged at full XLEN width.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In RUN, each read port compares rs_addr[i] with every enabled wr_addr[j] in the same cycle.
  - On a match, rs_data[i] = wr_data of the highest-index matching port; this is combinational write-to-read forwarding.
  - The zero-register rule still takes precedence: address 0 with ZERO_REG=1 reads 0.
  - No forwarding in CLEAR.
- Undefined: no forwarding; a read returns the stored value as described in Behaviour.

Decomposition:
- Package regfile_pkg:
  - state enum typedef (CLEAR, RUN).
  - addr_width function wrapping $clog2.
  - REG_ZERO constant (0).
- Sub-module regfile_rd_port, instantiated NRD times:
  - Inputs: one address, the array read value, state, and the write-port bundles.
  - Applies the zero-register rule, the CLEAR masking and (with REGFILE_BYPASS_EN) forwarding priority.
- The top level holds the array, the write-commit/collision logic and the clear FSM.

Test Plan:
- Reset, then rst_n high -> ready stays 0 for exactly 32 cycles, rises in cycle 33; all reads return 0 in the meantime.
- RUN: write 0xDEAD_BEEF_0000_0001 to reg 5 via port 0; next cycle read reg 5 on both ports -> both return 0xDEAD_BEEF_0000_0001.
- Write port 0 = 0x11 and port 1 = 0x22 to reg 7 in the same cycle -> reg 7 reads 0x22. Writing 0x33 to reg 0 -> reg 0 reads 0.
- Same-cycle write 0xAB to reg 3 while reading reg 3:
  - bypass off -> old value this cycle, 0xAB next cycle.
  - REGFILE_BYPASS_EN -> 0xAB this cycle.
- After populating regs 1..31, pulse clr_req -> ready low for 32 cycles, writes issued during that time are dropped, every register reads 0 afterwards.
- Assert rst_n low at clear cycle 10 -> clear restarts; ready rises exactly 32 cycles after rst_n returns high.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the multi-port register file.
//   state_t    : clear-engine state (CLEAR while zeroing the array, RUN after)
//   addr_width : register-address width for a given register count
//   REG_ZERO   : index of the optionally hardwired zero register
// Optional feature macro used by the register file: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Always at least one address bit, even for degenerate register counts.
    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One combinational read port of the register file.
// It takes the raw array value for its address and applies, in rising
// priority: write-to-read forwarding (REGFILE_BYPASS_EN only), masking to zero
// while the clear engine runs, and the hardwired-zero rule for register 0.
// Ports:
//   i_run     : 1 when the file is in RUN (0 = clearing, reads return 0)
//   i_addr    : read address
//   i_arr     : array contents at i_addr
//   i_wr_en   : per-port write enables (packed, NWR bits)
//   i_wr_addr : packed write addresses (port j at [j*AW +: AW])
//   i_wr_data : packed write data (port j at [j*XLEN +: XLEN])
//   o_data    : read result
// Macro: REGFILE_BYPASS_EN enables same-cycle write forwarding.
// -----------------------------------------------------------------------------
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          i_run,
    input  logic [$clog2(NREGS)-1:0]      i_addr,
    input  logic [XLEN-1:0]               i_arr,
    input  logic [NWR-1:0]                i_wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]  i_wr_addr,
    input  logic [NWR*XLEN-1:0]           i_wr_data,
    output logic [XLEN-1:0]               o_data
);

    localparam int AW = addr_width(NREGS);

    logic w_is_zero_reg;
    assign w_is_zero_reg = (ZERO_REG != 0) && (i_addr == AW'(REG_ZERO));

`ifndef REGFILE_BYPASS_EN
    // Write bundles only matter for forwarding.
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};
`endif

    always_comb begin
        o_data = i_arr;
`ifdef REGFILE_BYPASS_EN
        // Ascending scan: the last (highest-index) matching port wins,
        // mirroring the collision rule of the write-commit logic.
        for (int j = 0; j < NWR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr)) begin
                o_data = i_wr_data[j*XLEN +: XLEN];
            end
        end
`endif
        if (!i_run || w_is_zero_reg) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file with a sequential clear
// engine. After reset, or on clr_req while running, every register is zeroed
// one per cycle (NREGS cycles); ready is low for that whole time.
// Ports:
//   clk      : clock, all state updates on posedge
//   rst_n    : synchronous active-low reset (restarts the clear)
//   clr_req  : request a full re-clear, honoured only while ready
//   ready    : 1 when reads are valid and writes are accepted
//   rs_addr  : packed read addresses, port i at [i*AW +: AW]
//   rs_data  : packed read data, port i at [i*XLEN +: XLEN] (combinational)
//   wr_en    : per-port write enables
//   wr_addr  : packed write addresses
//   wr_data  : packed write data
// Macro: REGFILE_BYPASS_EN enables combinational write-to-read forwarding.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_req,
    output logic                          ready,
    input  logic [NRD*$clog2(NREGS)-1:0]  rs_addr,
    output logic [NRD*XLEN-1:0]           rs_data,
    input  logic [NWR-1:0]                wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]  wr_addr,
    input  logic [NWR*XLEN-1:0]           wr_data
);

    localparam int AW = addr_width(NREGS);

    state_t          r_state;
    logic [AW-1:0]   r_clr_ptr;
    logic            r_ready;
    logic [XLEN-1:0] r_regs [NREGS];

    // Clear FSM: only control state is reset; the array is zeroed by the
    // engine itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == AW'(NREGS - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_ptr <= '0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_ptr <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;

    // Array update. Ports are applied in ascending order so that on an
    // address collision the highest-index port's value is the one that lands.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_regs[r_clr_ptr] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] &&
                    !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == AW'(REG_ZERO)))) begin
                    r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    logic w_run;
    assign w_run = (r_state == RUN);

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_arr;

        assign w_addr = rs_addr[gi*AW +: AW];
        assign w_arr  = r_regs[w_addr];

        regfile_rd_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .i_run     (w_run),
            .i_addr    (w_addr),
            .i_arr     (w_arr),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_data    (rs_data[gi*XLEN +: XLEN])
        );
    end

endmodule
